// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two requester ports, the arbiter and the
// memory-controller request interface.
interface mem_port_arbiter_if;
   logic        f_req;
   logic [15:0] f_addr;
   logic        f_ack;
   logic        f_err;
   logic [15:0] f_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic        d_err;
   logic [15:0] d_rdata;
   logic        mc_request;
   logic        mc_request_type;
   logic [15:0] mc_request_address;
   logic [15:0] mc_data_out;
   logic [15:0] mc_data_in;
   logic        mc_memory_ready;
   logic        mc_write_complete;
   logic        busy;
   logic        grant;

   // Arbiter view: requests and controller responses in, everything else out.
   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
      input  mc_data_in, mc_memory_ready, mc_write_complete,
      output f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
      output mc_request, mc_request_type, mc_request_address, mc_data_out,
      output busy, grant
   );

   // Environment view: requesters plus the memory controller.
   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
      output mc_data_in, mc_memory_ready, mc_write_complete,
      input  f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
      input  mc_request, mc_request_type, mc_request_address, mc_data_out,
      input  busy, grant
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) round-robin arbiter and sequencer in front of the
// memory controller. One transaction at a time: the request is held for
// REQ_HOLD cycles, then the matching completion pulse (or a timeout) ends it
// with a one-cycle acknowledge to the granted port.
module mem_port_arbiter #(
   parameter int REQ_HOLD       = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam logic [15:0] HOLD_LAST    = 16'(REQ_HOLD - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic        PORT_FETCH   = 1'b0;
   localparam logic        PORT_DATA    = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_r, state_nx_s;
   logic        last_r, last_nx_s;
   logic [15:0] hold_cnt_r, hold_cnt_nx_s;
   logic [15:0] wait_cnt_r, wait_cnt_nx_s;
   logic        pick_data_s;
   logic        complete_s;

   logic        mc_request_nx_s;
   logic        mc_type_nx_s;
   logic [15:0] mc_addr_nx_s;
   logic [15:0] mc_dout_nx_s;
   logic        f_ack_nx_s, f_err_nx_s;
   logic [15:0] f_rdata_nx_s;
   logic        d_ack_nx_s, d_err_nx_s;
   logic [15:0] d_rdata_nx_s;
   logic        busy_nx_s;
   logic        grant_nx_s;

   // Data wins only when fetch is not asking or fetch was the last one served.
   assign pick_data_s = bus.d_req & (~bus.f_req | (last_r == PORT_FETCH));

   // Only the pulse matching the in-flight transaction type completes it.
   assign complete_s = bus.mc_request_type ? bus.mc_write_complete : bus.mc_memory_ready;

   // Next-state and next-output logic; every registered output holds by default.
   always_comb begin
      state_nx_s      = state_r;
      last_nx_s       = last_r;
      hold_cnt_nx_s   = hold_cnt_r;
      wait_cnt_nx_s   = wait_cnt_r;
      mc_request_nx_s = 1'b0;
      mc_type_nx_s    = bus.mc_request_type;
      mc_addr_nx_s    = bus.mc_request_address;
      mc_dout_nx_s    = bus.mc_data_out;
      f_ack_nx_s      = 1'b0;
      f_err_nx_s      = bus.f_err;
      f_rdata_nx_s    = bus.f_rdata;
      d_ack_nx_s      = 1'b0;
      d_err_nx_s      = bus.d_err;
      d_rdata_nx_s    = bus.d_rdata;
      grant_nx_s      = bus.grant;

      case (state_r)
         S_IDLE: begin
            if (bus.f_req | bus.d_req) begin
               state_nx_s      = S_ISSUE;
               hold_cnt_nx_s   = 16'd0;
               mc_request_nx_s = 1'b1;
               grant_nx_s      = pick_data_s;
               mc_addr_nx_s    = pick_data_s ? bus.d_addr : bus.f_addr;
               mc_type_nx_s    = pick_data_s & bus.d_we;
               mc_dout_nx_s    = pick_data_s ? bus.d_wdata : 16'h0000;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (hold_cnt_r == HOLD_LAST) begin
               state_nx_s    = S_WAIT;
               wait_cnt_nx_s = 16'd0;
            end else begin
               hold_cnt_nx_s   = hold_cnt_r + 16'd1;
               mc_request_nx_s = 1'b1;
            end
         end
         S_WAIT: begin
            if (complete_s) begin
               state_nx_s = S_DONE;
               if (bus.grant == PORT_DATA) begin
                  d_ack_nx_s = 1'b1;
                  d_err_nx_s = 1'b0;
                  if (~bus.mc_request_type) begin
                     d_rdata_nx_s = bus.mc_data_in;
                  end else begin
                     d_rdata_nx_s = bus.d_rdata;
                  end
               end else begin
                  f_ack_nx_s   = 1'b1;
                  f_err_nx_s   = 1'b0;
                  f_rdata_nx_s = bus.mc_data_in;
               end
            end else if (wait_cnt_r == TIMEOUT_LAST) begin
               state_nx_s = S_DONE;
               if (bus.grant == PORT_DATA) begin
                  d_ack_nx_s = 1'b1;
                  d_err_nx_s = 1'b1;
               end else begin
                  f_ack_nx_s = 1'b1;
                  f_err_nx_s = 1'b1;
               end
            end else begin
               wait_cnt_nx_s = wait_cnt_r + 16'd1;
            end
         end
         S_DONE: begin
            state_nx_s = S_IDLE;
            last_nx_s  = bus.grant;
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase

      busy_nx_s = (state_nx_s != S_IDLE);
   end

   // State, counters and all outputs; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r                <= S_IDLE;
         last_r                 <= PORT_DATA;
         hold_cnt_r             <= 16'd0;
         wait_cnt_r             <= 16'd0;
         bus.mc_request         <= 1'b0;
         bus.mc_request_type    <= 1'b0;
         bus.mc_request_address <= 16'h0000;
         bus.mc_data_out        <= 16'h0000;
         bus.f_ack              <= 1'b0;
         bus.f_err              <= 1'b0;
         bus.f_rdata            <= 16'h0000;
         bus.d_ack              <= 1'b0;
         bus.d_err              <= 1'b0;
         bus.d_rdata            <= 16'h0000;
         bus.busy               <= 1'b0;
         bus.grant              <= PORT_FETCH;
      end else begin
         state_r                <= state_nx_s;
         last_r                 <= last_nx_s;
         hold_cnt_r             <= hold_cnt_nx_s;
         wait_cnt_r             <= wait_cnt_nx_s;
         bus.mc_request         <= mc_request_nx_s;
         bus.mc_request_type    <= mc_type_nx_s;
         bus.mc_request_address <= mc_addr_nx_s;
         bus.mc_data_out        <= mc_dout_nx_s;
         bus.f_ack              <= f_ack_nx_s;
         bus.f_err              <= f_err_nx_s;
         bus.f_rdata            <= f_rdata_nx_s;
         bus.d_ack              <= d_ack_nx_s;
         bus.d_err              <= d_err_nx_s;
         bus.d_rdata            <= d_rdata_nx_s;
         bus.busy               <= busy_nx_s;
         bus.grant              <= grant_nx_s;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-timeline model (grant time, hold window, completion time).
module tb_mem_port_arbiter;
   localparam int H = 2;
   localparam int T = 20;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.REQ_HOLD(H), .TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: the current transaction is described by its grant cycle m_g and
   // its ack cycle m_done (-1 while still unknown).
   bit          m_active;
   int          m_g;
   int          m_done;
   bit          m_port;
   bit          m_we;
   bit          m_last;
   logic        e_mc_request, e_mc_request_type, e_busy, e_grant;
   logic        e_f_ack, e_f_err, e_d_ack, e_d_err;
   logic [15:0] e_mc_request_address, e_mc_data_out, e_f_rdata, e_d_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_outputs();
      chk("mc_request", 32'(bus.mc_request), 32'(e_mc_request));
      chk("mc_request_type", 32'(bus.mc_request_type), 32'(e_mc_request_type));
      chk("mc_request_address", 32'(bus.mc_request_address), 32'(e_mc_request_address));
      chk("mc_data_out", 32'(bus.mc_data_out), 32'(e_mc_data_out));
      chk("f_ack", 32'(bus.f_ack), 32'(e_f_ack));
      chk("f_err", 32'(bus.f_err), 32'(e_f_err));
      chk("f_rdata", 32'(bus.f_rdata), 32'(e_f_rdata));
      chk("d_ack", 32'(bus.d_ack), 32'(e_d_ack));
      chk("d_err", 32'(bus.d_err), 32'(e_d_err));
      chk("d_rdata", 32'(bus.d_rdata), 32'(e_d_rdata));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("grant", 32'(bus.grant), 32'(e_grant));
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_done   = -1;
      m_last   = 1'b1;
      e_mc_request = 1'b0; e_mc_request_type = 1'b0;
      e_mc_request_address = 16'h0000; e_mc_data_out = 16'h0000;
      e_f_ack = 1'b0; e_f_err = 1'b0; e_f_rdata = 16'h0000;
      e_d_ack = 1'b0; e_d_err = 1'b0; e_d_rdata = 16'h0000;
      e_busy = 1'b0; e_grant = 1'b0;
   endtask

   // Predict the outputs of cycle cyc+1 from the inputs driven in cycle cyc.
   task automatic model_advance();
      bit ok;
      if (reset) begin
         model_reset();
         return;
      end
      e_f_ack = 1'b0;
      e_d_ack = 1'b0;
      if (m_active) begin
         if (m_done < 0 && cyc >= m_g + H) begin
            ok = m_we ? bus.mc_write_complete : bus.mc_memory_ready;
            if (ok || cyc == m_g + H + T - 1) begin
               m_done = cyc + 1;
               if (m_port) begin
                  e_d_ack = 1'b1;
                  e_d_err = !ok;
                  if (ok && !m_we) e_d_rdata = bus.mc_data_in;
               end else begin
                  e_f_ack = 1'b1;
                  e_f_err = !ok;
                  if (ok) e_f_rdata = bus.mc_data_in;
               end
            end
         end
         e_mc_request = (cyc + 1 <= m_g + H - 1);
         if (m_done >= 0 && cyc == m_done) begin
            m_active = 1'b0;
            m_last   = m_port;
            e_busy   = 1'b0;
         end
      end else if (bus.f_req || bus.d_req) begin
         m_port   = bus.d_req && (!bus.f_req || !m_last);
         m_we     = m_port ? bus.d_we : 1'b0;
         m_g      = cyc + 1;
         m_done   = -1;
         m_active = 1'b1;
         e_mc_request         = 1'b1;
         e_busy               = 1'b1;
         e_grant              = m_port;
         e_mc_request_type    = m_we;
         e_mc_request_address = m_port ? bus.d_addr : bus.f_addr;
         e_mc_data_out        = m_port ? bus.d_wdata : 16'h0000;
      end
   endtask

   // Advance one clock with the currently driven inputs and check the new cycle.
   task automatic step();
      model_advance();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_outputs();
   endtask

   // One directed transaction issued from IDLE. The correct pulse comes
   // `lat` cycles into WAIT (WAIT begins 3 cycles after the request is
   // raised); lat < 0 means the controller never answers.
   task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] rd,
                      input int lat, input bit stray,
                      output int ack_rel, output int req_cycles,
                      output int wait_rel, output bit hold_ok);
      ack_rel = -1; req_cycles = 0; wait_rel = -1; hold_ok = 1'b1;
      if (port) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
         bus.f_req = 1'b1; bus.f_addr = addr;
      end
      for (int i = 0; i < 60 && ack_rel < 0; i++) begin
         bus.mc_memory_ready   = 1'b0;
         bus.mc_write_complete = 1'b0;
         bus.mc_data_in        = 16'($urandom);
         if (stray && i == 1) bus.mc_memory_ready = 1'b1;
         if (stray && i == 3) bus.mc_write_complete = 1'b1;
         if (lat >= 0 && i == 3 + lat) begin
            if (we) begin
               bus.mc_write_complete = 1'b1;
            end else begin
               bus.mc_memory_ready = 1'b1;
               bus.mc_data_in      = rd;
            end
         end
         step();
         if (bus.mc_request) req_cycles++;
         if (wait_rel < 0 && req_cycles > 0 && !bus.mc_request) wait_rel = i + 1;
         if (bus.busy && (bus.mc_request_address !== addr ||
                          bus.mc_request_type !== (port & we) ||
                          bus.mc_data_out !== (port ? wdata : 16'h0000))) hold_ok = 1'b0;
         if (port ? bus.d_ack : bus.f_ack) ack_rel = i + 1;
      end
      bus.mc_memory_ready   = 1'b0;
      bus.mc_write_complete = 1'b0;
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
      step();
   endtask

   initial begin
      int         ack_rel, req_cycles, wait_rel, n;
      bit         hold_ok, quiet;
      logic [3:0] seq;

      reset = 1'b1;
      bus.f_req = 1'b0; bus.f_addr = 16'h0000;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000;
      bus.mc_data_in = 16'h0000; bus.mc_memory_ready = 1'b0; bus.mc_write_complete = 1'b0;
      model_reset();
      @(negedge clk);
      step();
      step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_mc_request", 32'(bus.mc_request), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_f_rdata", 32'(bus.f_rdata), 32'd0);
      reset = 1'b0;
      step();

      // Fetch read answered two cycles into WAIT.
      txn(1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 2, 1'b0, ack_rel, req_cycles, wait_rel, hold_ok);
      chk("fetch_ack_latency", 32'(ack_rel), 32'd6);
      chk("fetch_req_cycles", 32'(req_cycles), 32'd2);
      chk("fetch_wait_entry", 32'(wait_rel), 32'd3);
      chk("fetch_hold", 32'(hold_ok), 32'd1);
      chk("fetch_rdata", 32'(bus.f_rdata), 32'h0000BEEF);
      chk("fetch_err", 32'(bus.f_err), 32'd0);

      // Data write: type/data held through WAIT, read data untouched.
      txn(1'b1, 1'b1, 16'h00FF, 16'hA55A, 16'h0000, 4, 1'b0, ack_rel, req_cycles, wait_rel, hold_ok);
      chk("write_ack_latency", 32'(ack_rel), 32'd8);
      chk("write_hold", 32'(hold_ok), 32'd1);
      chk("write_d_rdata", 32'(bus.d_rdata), 32'd0);
      chk("write_grant", 32'(bus.grant), 32'd1);

      // Data read with a stray ready during ISSUE and a wrong-type pulse in WAIT.
      txn(1'b1, 1'b0, 16'h0777, 16'h0000, 16'h1357, 3, 1'b1, ack_rel, req_cycles, wait_rel, hold_ok);
      chk("stray_ack_latency", 32'(ack_rel), 32'd7);
      chk("stray_rdata", 32'(bus.d_rdata), 32'h00001357);

      // Data read with no answer: error ack exactly T cycles after WAIT entry.
      txn(1'b1, 1'b0, 16'h2222, 16'h0000, 16'h0000, -1, 1'b0, ack_rel, req_cycles, wait_rel, hold_ok);
      chk("timeout_ack_latency", 32'(ack_rel), 32'd23);
      chk("timeout_after_wait", 32'(ack_rel - wait_rel), 32'd20);
      chk("timeout_err", 32'(bus.d_err), 32'd1);
      chk("timeout_rdata_kept", 32'(bus.d_rdata), 32'h00001357);
      bus.mc_memory_ready = 1'b1;
      repeat (3) step();
      bus.mc_memory_ready = 1'b0;
      chk("late_ready_busy", 32'(bus.busy), 32'd0);
      chk("late_ready_err_kept", 32'(bus.d_err), 32'd1);

      // Reset in the middle of WAIT, then a normal fetch.
      bus.f_req = 1'b1; bus.f_addr = 16'h4321;
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.f_req = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_f_ack", 32'(bus.f_ack), 32'd0);
      chk("midrst_addr", 32'(bus.mc_request_address), 32'd0);
      step();
      txn(1'b0, 1'b0, 16'hCAFE, 16'h0000, 16'h9999, 0, 1'b0, ack_rel, req_cycles, wait_rel, hold_ok);
      chk("postrst_ack_latency", 32'(ack_rel), 32'd4);
      chk("postrst_rdata", 32'(bus.f_rdata), 32'h00009999);

      // Both ports held after reset: grants must alternate fetch, data, fetch, data.
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.f_req = 1'b1; bus.f_addr = 16'h0F00;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0D00;
      bus.mc_memory_ready = 1'b1;
      seq = 4'd0;
      n   = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         bus.mc_data_in = bus.mc_request_address ^ 16'h5A5A;
         step();
         if (bus.f_ack) begin
            seq = {seq[2:0], 1'b0}; n++;
            chk("tie_f_rdata", 32'(bus.f_rdata), 32'h0000555A);
         end
         if (bus.d_ack) begin
            seq = {seq[2:0], 1'b1}; n++;
            chk("tie_d_rdata", 32'(bus.d_rdata), 32'h0000575A);
         end
      end
      chk("tie_count", 32'(n), 32'd4);
      chk("tie_order", 32'(seq), 32'b0101);
      bus.f_req = 1'b0; bus.d_req = 1'b0; bus.mc_memory_ready = 1'b0;
      step();
      step();

      // Randomized traffic; every fourth window starves the controller to force timeouts.
      for (int k = 0; k < 3000; k++) begin
         quiet = ((k / 250) % 4) == 3;
         if (bus.f_req && e_f_ack) begin
            if ($urandom_range(1) == 0) bus.f_req = 1'b0;
            else bus.f_addr = 16'($urandom);
         end else if (!bus.f_req && $urandom_range(3) == 0) begin
            bus.f_req = 1'b1; bus.f_addr = 16'($urandom);
         end
         if (bus.d_req && e_d_ack) begin
            if ($urandom_range(1) == 0) begin
               bus.d_req = 1'b0;
            end else begin
               bus.d_we = 1'($urandom_range(1)); bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
            end
         end else if (!bus.d_req && $urandom_range(3) == 0) begin
            bus.d_req = 1'b1;
            bus.d_we = 1'($urandom_range(1)); bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
         end
         bus.mc_memory_ready   = !quiet && ($urandom_range(7) == 0);
         bus.mc_write_complete = !quiet && ($urandom_range(7) == 0);
         bus.mc_data_in        = 16'($urandom);
         reset                 = ($urandom_range(499) == 0);
         step();
      end

      reset = 1'b0;
      bus.f_req = 1'b0; bus.d_req = 1'b0;
      bus.mc_memory_ready = 1'b0; bus.mc_write_complete = 1'b0;
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
